// File: rtl/axi_stream_sync_fifo_pkg.sv
// Shared AXI-Stream payload packing helpers for the sync FIFO and future stream stages.
// Beat field order (MSB..LSB): {tuser, tdest, tid, tlast, tkeep, tstrb, tdata}.
package axi_stream_sync_fifo_pkg;

  function automatic int payload_w(input int byte_width, input int id_width,
                                   input int dest_width, input int user_width);
    return 8*byte_width + 2*byte_width + 1 + id_width + dest_width + user_width;
  endfunction

  function automatic int last_bit(input int byte_width);
    return 10*byte_width;
  endfunction

endpackage

// File: rtl/axi_stream_fifo_mem.sv
// depth x width register array: synchronous write, asynchronous read.
module axi_stream_fifo_mem #(
  parameter int depth = 16,
  parameter int width = 44,
  localparam int addr_w = $clog2(depth)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [addr_w-1:0] waddr,
  input  logic [width-1:0]  wdata,
  input  logic [addr_w-1:0] raddr,
  output logic [width-1:0]  rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_stream_sync_fifo.sv
// First-word-fall-through AXI-Stream FIFO with occupancy and complete-packet counters.
module axi_stream_sync_fifo
  import axi_stream_sync_fifo_pkg::*;
#(
  parameter int byte_width = 4,
  parameter int id_width   = 1,
  parameter int dest_width = 1,
  parameter int user_width = 1,
  parameter int depth      = 16,
  localparam int addr_w    = $clog2(depth)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [8*byte_width-1:0] s_tdata,
  input  logic [byte_width-1:0]   s_tstrb,
  input  logic [byte_width-1:0]   s_tkeep,
  input  logic                    s_tlast,
  input  logic [id_width-1:0]     s_tid,
  input  logic [dest_width-1:0]   s_tdest,
  input  logic [user_width-1:0]   s_tuser,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [8*byte_width-1:0] m_tdata,
  output logic [byte_width-1:0]   m_tstrb,
  output logic [byte_width-1:0]   m_tkeep,
  output logic                    m_tlast,
  output logic [id_width-1:0]     m_tid,
  output logic [dest_width-1:0]   m_tdest,
  output logic [user_width-1:0]   m_tuser,
  output logic [addr_w:0]         level,
  output logic [addr_w:0]         pkt_count
);

  localparam int pw = payload_w(byte_width, id_width, dest_width, user_width);
  localparam int lw = addr_w + 1;
  localparam logic [addr_w:0] full_lvl = lw'(depth);

  logic [addr_w-1:0] wr_ptr, rd_ptr;
  logic [pw-1:0]     wr_data, rd_data;
  logic              push, pop;
  logic [addr_w:0]   level_next;

  assign push     = s_tvalid & s_tready;
  assign m_tvalid = (level != '0);
  assign pop      = m_tvalid & m_tready;

  assign wr_data = {s_tuser, s_tdest, s_tid, s_tlast, s_tkeep, s_tstrb, s_tdata};
  assign {m_tuser, m_tdest, m_tid, m_tlast, m_tkeep, m_tstrb, m_tdata} = rd_data;

  assign level_next = level + lw'(push) - lw'(pop);

  axi_stream_fifo_mem #(.depth(depth), .width(pw)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Ready looks only at our own occupancy, so a full FIFO cannot take a beat
  // in the same cycle it is popped; it reopens one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pkt_count <= '0;
      s_tready  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level     <= level_next;
      pkt_count <= pkt_count + lw'(push & s_tlast) - lw'(pop & rd_data[last_bit(byte_width)]);
      s_tready  <= (level_next != full_lvl);
    end
  end

endmodule

// File: tb/tb_axi_stream_sync_fifo.sv
// Directed + randomized bench for axi_stream_sync_fifo against a queue-based beat model.
module tb_axi_stream_sync_fifo;

  localparam int BW = 4;
  localparam int DEPTH = 16;
  localparam int PW = 10*BW + 4;

  logic clk = 1'b0;
  logic reset;
  logic s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
  logic [8*BW-1:0] s_tdata, m_tdata;
  logic [BW-1:0] s_tstrb, s_tkeep, m_tstrb, m_tkeep;
  logic [0:0] s_tid, s_tdest, s_tuser, m_tid, m_tdest, m_tuser;
  logic [4:0] level, pkt_count;

  int checks = 0;
  int failures = 0;

  logic [PW-1:0] q[$];
  logic          mdl_ready;

  always #5 clk = ~clk;

  axi_stream_sync_fifo #(.byte_width(BW), .id_width(1), .dest_width(1),
                         .user_width(1), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
    .level(level), .pkt_count(pkt_count)
  );

  function automatic int mdl_pkts();
    int n = 0;
    foreach (q[i]) if (q[i][10*BW]) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_beat(input logic last);
    s_tdata = $urandom;
    s_tstrb = 4'($urandom);
    s_tkeep = s_tstrb | 4'($urandom);
    s_tid   = 1'($urandom);
    s_tdest = 1'($urandom);
    s_tuser = 1'($urandom);
    s_tlast = last;
  endtask

  // Checks outputs against the model, then advances one clock and updates the model.
  task automatic cycle(input bit check_ready = 1);
    logic [PW-1:0] beat;
    bit push, pop;
    chk("m_tvalid", 64'(m_tvalid), 64'(q.size() != 0));
    chk("level", 64'(level), 64'(q.size()));
    chk("pkt_count", 64'(pkt_count), 64'(mdl_pkts()));
    if (check_ready) chk("s_tready", 64'(s_tready), 64'(mdl_ready));
    if (q.size() != 0)
      chk("m_payload", 64'({m_tuser, m_tdest, m_tid, m_tlast, m_tkeep, m_tstrb, m_tdata}),
          64'(q[0]));
    beat = {s_tuser, s_tdest, s_tid, s_tlast, s_tkeep, s_tstrb, s_tdata};
    push = s_tvalid && mdl_ready;
    pop  = (q.size() != 0) && m_tready;
    @(posedge clk);
    if (reset) begin
      q.delete();
      mdl_ready = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(beat);
      mdl_ready = (q.size() != DEPTH);
    end
    #1;
  endtask

  task automatic drain();
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) cycle();
    m_tready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; s_tvalid = 1'b1; m_tready = 1'b0;
    rand_beat(1'b0);
    mdl_ready = 1'b0;
    @(posedge clk); #1;

    // 1: reset with s_tvalid high, then release
    for (int i = 0; i < 3; i++) cycle();
    reset = 1'b0; s_tvalid = 1'b0;
    cycle();
    chk("ready_after_release", 64'(s_tready), 64'd1);

    // 2: single beat, held stable under backpressure
    s_tvalid = 1'b1; rand_beat(1'b1); s_tdata = 32'hDEADBEEF;
    cycle();
    s_tvalid = 1'b0;
    chk("deadbeef", 64'(m_tdata), 64'hDEADBEEF);
    chk("one_pkt", 64'(pkt_count), 64'd1);
    for (int i = 0; i < 5; i++) cycle();
    m_tready = 1'b1;
    cycle();
    m_tready = 1'b0;
    cycle();

    // 3: fill to full, overflow attempt, single pop reopens ready
    for (int i = 0; i < DEPTH + 1; i++) begin
      s_tvalid = 1'b1; rand_beat(1'b0); s_tdata = 32'(i);
      cycle();
    end
    chk("full_level", 64'(level), 64'(DEPTH));
    chk("full_ready", 64'(s_tready), 64'd0);
    m_tready = 1'b1; s_tvalid = 1'b1;
    cycle();   // pop while full: no push allowed
    m_tready = 1'b0; s_tvalid = 1'b0;
    chk("after_pop_ready", 64'(s_tready), 64'd1);
    chk("after_pop_level", 64'(level), 64'(DEPTH - 1));
    drain();

    // 4: 40 beats streaming, pointers wrap twice
    s_tvalid = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rand_beat(1'b0); s_tdata = 32'(i);
      cycle();
      if (i > 0) chk("stream_level", 64'(level), 64'd1);
    end
    drain();

    // 5: packets of 3,1,5
    begin
      int lens[3] = '{3, 1, 5};
      foreach (lens[p]) for (int b = 0; b < lens[p]; b++) begin
        s_tvalid = 1'b1; rand_beat(b == lens[p] - 1);
        cycle();
      end
    end
    s_tvalid = 1'b0;
    chk("pkt3", 64'(pkt_count), 64'd3);
    chk("lvl9", 64'(level), 64'd9);
    drain();

    // 6: reset mid-packet at level 7
    for (int i = 0; i < 7; i++) begin
      s_tvalid = 1'b1; rand_beat(1'b0);
      cycle();
    end
    s_tvalid = 1'b0;
    chk("lvl7", 64'(level), 64'd7);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_valid", 64'(m_tvalid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_pkts", 64'(pkt_count), 64'd0);
    cycle();

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      s_tvalid = ($urandom_range(3) != 0);
      m_tready = ($urandom_range(2) == 0);
      reset    = ($urandom_range(99) == 0);
      rand_beat(1'($urandom_range(3) == 0));
      cycle();
    end
    reset = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
